// File: rtl/imem_program_encoder.sv
// imem_program_encoder
// Turns symbolic LEGv8 instruction requests into 32-bit machine words and
// writes them one after another into instruction memory, starting at
// BASE_ADDR. Each request passes through IDLE -> ENC -> WRITE. An illegal
// op or an out-of-range immediate sets a sticky error and writes nothing.
module imem_program_encoder #(
  parameter int          DEPTH     = 64,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op,
  input  logic [4:0]    rd,
  input  logic [4:0]    rn,
  input  logic [4:0]    rm,
  input  logic [25:0]   imm,
  input  logic [1:0]    hw,
  output logic          imem_we,
  output logic [63:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    op_q;
  logic [4:0]    rd_q;
  logic [4:0]    rn_q;
  logic [4:0]    rm_q;
  logic [25:0]   imm_q;
  logic [1:0]    hw_q;
  logic          we_q;
  logic [63:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] count_q;
  logic          err_q;

  logic [31:0]   word_d;
  logic          legal_d;
  logic [63:0]   addr_d;

  // A zero-depth memory never accepts anything and is never reported full.
  assign full       = (DEPTH != 0) && (count_q == DEPTH_C);
  assign in_ready   = (state_q == S_IDLE) && !full && (DEPTH != 0);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;

  // Next word lands right after the last one written; count never exceeds
  // DEPTH-1 here because requests are refused once full.
  assign addr_d = BASE_ADDR + (64'(count_q) << 2);

  // Encode the latched request and decide whether its immediate fits.
  always_comb begin
    word_d  = 32'h0;
    legal_d = 1'b1;
    case (op_q)
      4'd0: word_d = {11'b10001011000, rm_q, 6'b000000, rn_q, rd_q};  // ADD
      4'd1: word_d = {11'b11001011000, rm_q, 6'b000000, rn_q, rd_q};  // SUB
      4'd2: word_d = {11'b10001010000, rm_q, 6'b000000, rn_q, rd_q};  // AND
      4'd3: word_d = {11'b10101010000, rm_q, 6'b000000, rn_q, rd_q};  // ORR
      4'd4: begin  // ADDI, 12-bit unsigned immediate
        word_d  = {10'b1001000100, imm_q[11:0], rn_q, rd_q};
        legal_d = (imm_q[25:12] == '0);
      end
      4'd5: begin  // SUBI, 12-bit unsigned immediate
        word_d  = {10'b1101000100, imm_q[11:0], rn_q, rd_q};
        legal_d = (imm_q[25:12] == '0);
      end
      4'd6: begin  // LDUR, 9-bit signed offset
        word_d  = {11'b11111000010, imm_q[8:0], 2'b00, rn_q, rd_q};
        legal_d = (imm_q[25:8] == '0) || (imm_q[25:8] == '1);
      end
      4'd7: begin  // STUR, 9-bit signed offset
        word_d  = {11'b11111000000, imm_q[8:0], 2'b00, rn_q, rd_q};
        legal_d = (imm_q[25:8] == '0) || (imm_q[25:8] == '1);
      end
      4'd8: begin  // CBZ, 19-bit signed branch offset
        word_d  = {8'b10110100, imm_q[18:0], rd_q};
        legal_d = (imm_q[25:18] == '0) || (imm_q[25:18] == '1);
      end
      4'd9: word_d = {6'b000101, imm_q};  // B, full 26-bit offset
      4'd10: begin  // MOVZ, 16-bit unsigned immediate with shift field
        word_d  = {9'b110100101, hw_q, imm_q[15:0], rd_q};
        legal_d = (imm_q[25:16] == '0);
      end
      default: legal_d = 1'b0;
    endcase
  end

  // Control FSM with registered write port; reset beats clear, clear beats
  // any request still in flight.
  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      state_q <= S_IDLE;
      op_q    <= 4'h0;
      rd_q    <= 5'h0;
      rn_q    <= 5'h0;
      rm_q    <= 5'h0;
      imm_q   <= 26'h0;
      hw_q    <= 2'h0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'h0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          we_q <= 1'b0;
          if (in_valid && in_ready) begin
            op_q    <= op;
            rd_q    <= rd;
            rn_q    <= rn;
            rm_q    <= rm;
            imm_q   <= imm;
            hw_q    <= hw;
            state_q <= S_ENC;
          end
        end
        S_ENC: begin
          if (legal_d) begin
            wdata_q <= word_d;
            addr_q  <= addr_d;
            we_q    <= 1'b1;
            state_q <= S_WRITE;
          end else begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_WRITE: begin
          we_q    <= 1'b0;
          count_q <= count_q + CW'(1);
          state_q <= S_IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_program_encoder.md
Name: imem_program_encoder

Overview:
Sequential encoder and loader that turns symbolic instruction requests (op enum plus register and immediate fields) into 32-bit LEGv8 machine words. It writes them sequentially into instruction memory. It produces exactly the opcode bit patterns the processor's control decoder matches, so test programs can be assembled in hardware before the core leaves reset. It sits between a bench or boot source and the instruction-memory write port.

Parameters:
DEPTH, 64, maximum number of instruction words loaded before full.
BASE_ADDR, 64'h0, byte address of the first instruction word.

Ports:
CLK  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
clear  input  1  synchronous restart: count=0, err=0, FSM to IDLE; does not affect memory contents.
in_valid  input  1  request valid.
in_ready  output  1  request accepted when in_valid & in_ready.
op  input  4  0 ADDREG, 1 SUBREG, 2 ANDREG, 3 ORRREG, 4 ADDIMM, 5 SUBIMM, 6 LDUR, 7 STUR, 8 CBZ, 9 B, 10 MOVZ; 11-15 illegal.
rd  input  5  Rd, or Rt for LDUR/STUR/CBZ.
rn  input  5  Rn.
rm  input  5  Rm, register forms only.
imm  input  26  immediate; signed for LDUR/STUR/CBZ/B, unsigned for ADDIMM/SUBIMM/MOVZ.
hw  input  2  MOVZ shift field.
imem_we  output  1  one-cycle write strobe.
imem_addr  output  64  byte address, BASE_ADDR + 4*count.
imem_wdata  output  32  encoded instruction.
count  output  log2(DEPTH)+1  words written so far.
full  output  1  count == DEPTH.
err  output  1  sticky error: illegal op or immediate out of range.

Behaviour:
- Reset or clear values: FSM IDLE, in_ready=1 (0 if DEPTH==0), imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err=0.
- Reset has priority over clear. Clear has priority over any in-flight request, which is dropped with no write.
- FSM states are IDLE, ENC and WRITE.
- IDLE: in_ready = !full. On handshake, latch op/rd/rn/rm/imm/hw and go to ENC.
- ENC: compute the word and the range check. If legal, go to WRITE. If not, set err and return to IDLE with no write and no count change.
- WRITE: imem_we=1 for exactly one cycle with registered addr/wdata. Next cycle: count+1, return to IDLE.
- Latency: handshake at edge N gives imem_we high in cycle N+2. The next request is accepted no earlier than edge N+3. in_ready=0 in ENC and WRITE.
- imem_addr and imem_wdata hold their last values while imem_we=0.
- Register forms: [31:21] opcode (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000), [20:16] rm, [15:10] 0, [9:5] rn, [4:0] rd.
- ADDIMM/SUBIMM: [31:22] 1001000100 or 1101000100, [21:10] imm[11:0], rn, rd. Legal only if imm[25:12]==0.
- LDUR/STUR: [31:21] 11111000010 or 11111000000, [20:12] imm[8:0], [11:10] 00, rn, rt. Legal only if imm[25:9] are all equal to imm[8].
- CBZ: [31:24] 10110100, [23:5] imm[18:0], [4:0] rt. Legal only if imm[25:19] are all equal to imm[18].
- B: [31:26] 000101, [25:0] imm. Always in range.
- MOVZ: [31:23] 110100101, [22:21] hw, [20:5] imm[15:0], [4:0] rd. Legal only if imm[25:16]==0.
- Illegal op codes 11-15 set err.
- Full: once count==DEPTH, full=1 and in_ready=0. count never wraps and imem_addr never exceeds BASE_ADDR+4*(DEPTH-1). A request held valid while full stays pending and is not consumed.
- err is sticky until reset or clear. Further legal requests still encode and write normally while err=1.

Test Plan:
- ADDREG rd=3 rn=1 rm=2 -> imem_we exactly 2 cycles after handshake; wdata=0x8B020023, addr=0x0, count 0->1.
- ADDIMM rd=9 rn=31 imm=0x10 -> 0x910043E9. Then LDUR rt=2 rn=10 imm=-8 -> 0xF85F8142 at addr 0x4.
- B imm=-1 -> 0x17FFFFFF. CBZ rt=7 imm=3 -> 0xB4000067. MOVZ rd=5 hw=1 imm=0xBEEF -> 0xD2B7DDE5.
- Error cases: ADDIMM imm=0x1000 -> no imem_we, err=1, count unchanged. op=12 -> same. A following legal ADDREG still writes and err stays 1.
- Full: DEPTH=4, issue 5 back-to-back requests -> 4 writes at 0x0/0x4/0x8/0xC, full=1, in_ready=0, 5th never accepted. Then clear -> count=0, full=0, next write at 0x0.
- Abort: assert reset (or clear) in the ENC or WRITE cycle -> no further imem_we, all outputs at reset values next cycle.
